// File: rtl/rr_arb2_stream.sv
// rtl/rr_arb2_stream.sv - two-input burst-limited round-robin stream arbiter with registered output stage
module rr_arb2_stream #(
  parameter int DATA_W = 8,
  parameter int BURST  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready
);

  localparam int CW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;

  owner_t            r_owner;
  logic [CW-1:0]     r_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_src;

  logic              w_load_en;
  logic              w_own_is1;
  logic              w_own_valid;
  logic              w_oth_valid;
  logic              w_cnt_below;
  logic              w_gnt;
  logic              w_gnt_src;
  logic [DATA_W-1:0] w_gnt_data;

  assign w_load_en   = !r_out_valid || out_ready;
  assign w_own_is1   = (r_owner == OWN1);
  assign w_own_valid = w_own_is1 ? in1_valid : in0_valid;
  assign w_oth_valid = w_own_is1 ? in0_valid : in1_valid;
  assign w_cnt_below = (r_cnt < CNT_MAX);

  // Burst cap only bites when the other source is actually waiting.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_src = 1'b0;
    if (w_load_en) begin
      if (w_own_valid && (!w_oth_valid || w_cnt_below)) begin
        w_gnt     = 1'b1;
        w_gnt_src = w_own_is1;
      end else if (w_oth_valid) begin
        w_gnt     = 1'b1;
        w_gnt_src = !w_own_is1;
      end
    end
  end

  assign w_gnt_data = w_gnt_src ? in1_data : in0_data;

  assign in0_ready = rst_n && w_gnt && !w_gnt_src;
  assign in1_ready = rst_n && w_gnt &&  w_gnt_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_src   <= w_gnt_src;
        if (w_gnt_src == w_own_is1) begin
          if (w_cnt_below) r_cnt <= r_cnt + CNT_ONE;
        end else begin
          r_owner <= w_gnt_src ? OWN1 : OWN0;
          r_cnt   <= CNT_ONE;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
